pal_config_loader: RTL

- Configuration controller for the PAL fuse array in the TinyTapeout top.
- Accepts a framed byte stream (sync byte, fuse bytes, checksum) over a valid/ready interface.
- Serialises the fuse bytes into the PAL's fuse shift chain, LSB-first.
- Commits the configuration with a latch pulse only when the checksum matches, and holds the PAL outputs gated while a load is in progress.

---
 rtl/pal_config_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pal_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : pal_config_loader
// Description : Loads a framed, checksummed byte stream into the PAL fuse
//               shift chain (LSB-first) and commits it with a latch pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pal_config_loader #(
    parameter int         CFG_BITS  = 128,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    input  logic [7:0]                          cmd_data,
    input  logic                                cmd_abort,
    output logic                                cmd_ready,
    output logic                                cfg_shift_en,
    output logic                                cfg_shift_data,
    output logic                                cfg_latch,
    output logic                                cfg_valid,
    output logic                                busy,
    output logic                                error,
    output logic [$clog2(CFG_BITS/8+1)-1:0]     byte_count
);

    localparam int                 c_cnt_w     = $clog2(CFG_BITS/8+1);
    localparam logic [c_cnt_w-1:0] c_num_bytes = c_cnt_w'(CFG_BITS/8);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_data_wait = 3'd1;
    localparam logic [2:0] c_st_shift     = 3'd2;
    localparam logic [2:0] c_st_csum_wait = 3'd3;
    localparam logic [2:0] c_st_latch     = 3'd4;
    localparam logic [2:0] c_st_err       = 3'd5;

    logic [2:0]         r_state;
    logic [7:0]         r_shreg;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_csum;
    logic [c_cnt_w-1:0] r_byte_count;
    logic               r_cfg_valid;
    logic               r_error;
    logic               w_accept;

    // Handshake and chain controls decode directly from the state register.
    always_comb begin
        cmd_ready = 1'b0;
        case (r_state)
            c_st_idle, c_st_data_wait, c_st_csum_wait, c_st_err: cmd_ready = 1'b1;
            default:                                             cmd_ready = 1'b0;
        endcase
    end

    assign w_accept       = cmd_valid && cmd_ready;
    assign cfg_shift_en   = (r_state == c_st_shift);
    assign cfg_shift_data = (r_state == c_st_shift) ? r_shreg[0] : 1'b0;
    assign cfg_latch      = (r_state == c_st_latch);
    assign busy           = (r_state != c_st_idle) && (r_state != c_st_err);
    assign cfg_valid      = r_cfg_valid;
    assign error          = r_error;
    assign byte_count     = r_byte_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_shreg      <= 8'd0;
            r_bit_cnt    <= 3'd0;
            r_csum       <= 8'd0;
            r_byte_count <= '0;
            r_cfg_valid  <= 1'b0;
            r_error      <= 1'b0;
        end else if (cmd_abort && (r_state != c_st_idle)) begin
            // Abort truncates any in-flight shift; error and byte_count are kept.
            r_state     <= c_st_idle;
            r_cfg_valid <= 1'b0;
            r_bit_cnt   <= 3'd0;
        end else begin
            case (r_state)
                c_st_idle, c_st_err: begin
                    if (w_accept && (cmd_data == SYNC_BYTE)) begin
                        r_state      <= c_st_data_wait;
                        r_byte_count <= '0;
                        r_csum       <= 8'd0;
                        r_cfg_valid  <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                c_st_data_wait: begin
                    if (w_accept) begin
                        r_shreg   <= cmd_data;
                        r_csum    <= r_csum ^ cmd_data;
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_st_shift;
                        if (r_byte_count != c_num_bytes) begin
                            r_byte_count <= r_byte_count + c_cnt_w'(1);
                        end
                    end
                end
                c_st_shift: begin
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= (r_byte_count == c_num_bytes) ? c_st_csum_wait
                                                                 : c_st_data_wait;
                    end
                end
                c_st_csum_wait: begin
                    if (w_accept) begin
                        if (cmd_data == r_csum) begin
                            r_state <= c_st_latch;
                        end else begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end
                    end
                end
                c_st_latch: begin
                    r_cfg_valid <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
